// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with leading-zero
// blanking. A prescaled slot counter steps the digit index that steers a 2:1 mux tree.
module seg_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  blank_lz,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  tick
);
    localparam int IW     = $clog2(DIGITS);
    localparam int CW     = $clog2(PRESCALE);
    localparam int LEAVES = 1 << IW;

    logic [CW-1:0]     cnt_reg;
    logic [IW-1:0]     idx_reg;
    logic              tick_reg;
    logic [DIGITS-1:0] an_reg;
    logic [6:0]        seg_reg;
    logic              dp_reg;

    // zero_above[i]: digits i..DIGITS-1 are all zero
    logic [DIGITS:1]   zero_above;
    assign zero_above[DIGITS] = 1'b1;

    generate
        for (genvar gi = 1; gi < DIGITS; gi++) begin : g_lz
            assign zero_above[gi] = (digits_in[4*gi +: 4] == 4'h0) && zero_above[gi+1];
        end
    endgenerate

    // Heap-ordered mux tree: node k has children 2k+1 (sel=0) and 2k+2 (sel=1).
    // Each node carries {blank, dp, hex}.
    logic [5:0] node [2*LEAVES-1];

    generate
        for (genvar gi = 0; gi < LEAVES; gi++) begin : g_leaf
            if (gi == 0) begin : g_d0
                assign node[LEAVES-1] = {1'b0, dp_in[0], digits_in[3:0]};
            end else if (gi < DIGITS) begin : g_dn
                assign node[LEAVES-1+gi] = {blank_lz & zero_above[gi], dp_in[gi], digits_in[4*gi +: 4]};
            end else begin : g_pad
                assign node[LEAVES-1+gi] = 6'b0;
            end
        end
        for (genvar gi = 0; gi < LEAVES-1; gi++) begin : g_mux
            localparam int DEPTH = $clog2(gi + 2) - 1;
            assign node[gi] = idx_reg[IW-1-DEPTH] ? node[2*gi+2] : node[2*gi+1];
        end
    endgenerate

    logic [5:0] sel_node;
    logic [6:0] seg_dec;
    assign sel_node = node[0];

    always_comb begin
        seg_dec = 7'h7F;
        case (sel_node[3:0])
            4'h0: seg_dec = 7'h40;
            4'h1: seg_dec = 7'h79;
            4'h2: seg_dec = 7'h24;
            4'h3: seg_dec = 7'h30;
            4'h4: seg_dec = 7'h19;
            4'h5: seg_dec = 7'h12;
            4'h6: seg_dec = 7'h02;
            4'h7: seg_dec = 7'h78;
            4'h8: seg_dec = 7'h00;
            4'h9: seg_dec = 7'h10;
            4'hA: seg_dec = 7'h08;
            4'hB: seg_dec = 7'h03;
            4'hC: seg_dec = 7'h46;
            4'hD: seg_dec = 7'h21;
            4'hE: seg_dec = 7'h06;
            4'hF: seg_dec = 7'h0E;
            default: seg_dec = 7'h7F;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= '0;
            idx_reg  <= '0;
            tick_reg <= 1'b0;
            an_reg   <= '1;
            seg_reg  <= 7'h7F;
            dp_reg   <= 1'b1;
        end else if (en) begin
            if (cnt_reg == CW'(PRESCALE-1)) begin
                cnt_reg  <= '0;
                idx_reg  <= (idx_reg == IW'(DIGITS-1)) ? '0 : idx_reg + 1'b1;
                tick_reg <= 1'b1;
            end else begin
                cnt_reg  <= cnt_reg + 1'b1;
                tick_reg <= 1'b0;
            end
            // Outputs reflect the pre-advance index, so they trail idx by a cycle
            an_reg  <= ~(DIGITS'(1) << idx_reg);
            seg_reg <= sel_node[5] ? 7'h7F : seg_dec;
            dp_reg  <= ~sel_node[4];
        end else begin
            tick_reg <= 1'b0;
            an_reg   <= '1;
            seg_reg  <= 7'h7F;
            dp_reg   <= 1'b1;
        end
    end

    assign an   = an_reg;
    assign seg  = seg_reg;
    assign dp   = dp_reg;
    assign tick = tick_reg;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a driver pushes model-predicted outputs,
// a monitor pops and compares them one cycle at a time.
module tb_seg_scan_ctrl;
    localparam int D = 4;
    localparam int P = 4;

    logic           clk = 1'b1;
    logic           reset, en, blank_lz;
    logic [4*D-1:0] digits_in;
    logic [D-1:0]   dp_in;
    logic [D-1:0]   an;
    logic [6:0]     seg;
    logic           dp, tick;

    seg_scan_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk(clk), .reset(reset), .en(en), .blank_lz(blank_lz),
        .digits_in(digits_in), .dp_in(dp_in),
        .an(an), .seg(seg), .dp(dp), .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [D-1:0] an;
        logic [6:0]   seg;
        logic         dp;
        logic         tick;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         m_cnt = 0;
    int         m_idx = 0;
    bit         done = 0;
    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: predicts the registered outputs after the coming edge.
    function automatic exp_t model_step(input logic r, input logic e, input logic b,
                                        input logic [4*D-1:0] dg, input logic [D-1:0] dpi);
        exp_t x;
        int   hex;
        bit   blank;
        x.an = '1; x.seg = 7'h7F; x.dp = 1'b1; x.tick = 1'b0;
        if (r) begin
            m_cnt = 0;
            m_idx = 0;
        end else if (e) begin
            hex   = int'((dg >> (4*m_idx)) & 16'hF);
            blank = b && (m_idx > 0) && ((dg >> (4*m_idx)) == 0);
            x.an  = ~(D'(1) << m_idx);
            x.seg = blank ? 7'h7F : seg_tbl[hex];
            x.dp  = ~dpi[m_idx];
            if (m_cnt == P-1) begin
                m_cnt  = 0;
                m_idx  = (m_idx + 1) % D;
                x.tick = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        return x;
    endfunction

    task automatic cyc(input logic r, input logic e, input logic b,
                       input logic [4*D-1:0] dg, input logic [D-1:0] dpi);
        @(negedge clk);
        reset = r; en = e; blank_lz = b; digits_in = dg; dp_in = dpi;
        sb.push_back(model_step(r, e, b, dg, dpi));
    endtask

    // Monitor
    initial begin
        exp_t x;
        while (!done) begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                x = sb.pop_front();
                checks += 4;
                if (an !== x.an) begin
                    errors++; $display("FAIL an: got %h expected %h", an, x.an);
                end
                if (seg !== x.seg) begin
                    errors++; $display("FAIL seg: got %h expected %h", seg, x.seg);
                end
                if (dp !== x.dp) begin
                    errors++; $display("FAIL dp: got %b expected %b", dp, x.dp);
                end
                if (tick !== x.tick) begin
                    errors++; $display("FAIL tick: got %b expected %b", tick, x.tick);
                end
                $display("t=%0t an=%h seg=%h dp=%b tick=%b", $time, an, seg, dp, tick);
            end
        end
    end

    // Driver
    initial begin
        reset = 1'b1; en = 1'b1; blank_lz = 1'b0; digits_in = '0; dp_in = '0;
        // Reset, then the full scan pattern
        repeat (2) cyc(1, 1, 0, 16'h3A81, 4'b0100);
        repeat (20) cyc(0, 1, 0, 16'h3A81, 4'b0100);
        // Decode sweep on digit 0 right after reset
        for (int v = 0; v < 16; v++) begin
            cyc(1, 1, 0, 16'h0000, 4'b0000);
            repeat (2) cyc(0, 1, 0, 16'(v), 4'b0001);
        end
        // Leading-zero blanking
        cyc(1, 1, 1, 16'h0020, 4'b0000);
        repeat (16) cyc(0, 1, 1, 16'h0020, 4'b1010);
        repeat (16) cyc(0, 1, 1, 16'h0000, 4'b0000);
        repeat (16) cyc(0, 1, 0, 16'h0000, 4'b0000);
        // Enable drop at idx=2, count=1
        for (int i = 0; i < 32 && !(m_idx == 2 && m_cnt == 1); i++)
            cyc(0, 1, 0, 16'h3A81, 4'b0100);
        repeat (10) cyc(0, 0, 0, 16'h3A81, 4'b0100);
        repeat (8) cyc(0, 1, 0, 16'h3A81, 4'b0100);
        // Reset mid-scan at idx=3
        for (int i = 0; i < 32 && m_idx != 3; i++)
            cyc(0, 1, 0, 16'h1234, 4'b0011);
        cyc(1, 1, 0, 16'h1234, 4'b0011);
        repeat (10) cyc(0, 1, 0, 16'h1234, 4'b0011);
        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [4*D-1:0] dg;
            dg = 16'($urandom);
            if ($urandom_range(0, 3) == 0) dg = dg & 16'h00FF;
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0),
                1'($urandom), dg, 4'($urandom));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        done = 1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
